// File: rtl/matrix_scroll_feeder.sv
// matrix_scroll_feeder: buffers 5-bit pixel columns in a small FIFO and scrolls
// them right-to-left through a 5x5 frame, one column per SCROLL_DIV enabled
// cycles. Keeps scrolling blank columns after the FIFO drains until the frame
// is empty, then idles.
//
// Ports:
//   PIXEL_CLK    - single clock, rising edge
//   RST          - synchronous active-high reset, highest priority
//   I_enable     - scroll counter advances only while high
//   I_clear      - one-cycle request: blank frame, empty FIFO, go idle
//   I_col_data   - column to append, bit r = row r
//   I_col_valid  - I_col_data is valid
//   O_col_ready  - FIFO not full (registered)
//   row0..row4   - frame rows, bit c = column c, column 4 is the entry edge
//   O_shift      - one-cycle pulse in the cycle after a scroll step
//   O_empty      - FIFO empty
//   O_count      - FIFO occupancy
module matrix_scroll_feeder #(
    parameter int unsigned SCROLL_DIV = 10_000_000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          PIXEL_CLK,
    input  logic                          RST,
    input  logic                          I_enable,
    input  logic                          I_clear,
    input  logic [4:0]                    I_col_data,
    input  logic                          I_col_valid,
    output logic                          O_col_ready,
    output logic [4:0]                    row0,
    output logic [4:0]                    row1,
    output logic [4:0]                    row2,
    output logic [4:0]                    row3,
    output logic [4:0]                    row4,
    output logic                          O_shift,
    output logic                          O_empty,
    output logic [$clog2(FIFO_DEPTH):0]   O_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [31:0] DivLast = 32'(SCROLL_DIV - 1);
    localparam logic [CW-1:0] CountFull = CW'(FIFO_DEPTH);

    typedef enum logic {StIdle, StScroll} state_e;

    state_e          state_q;
    logic [31:0]     div_cnt_q;
    logic [4:0]      rows_q [5];
    logic [4:0]      rows_d [5];
    logic            shift_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            ready_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [4:0]      mem [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic            step;
    logic            fifo_empty;
    logic            frame_zero;
    logic [4:0]      new_col;

    assign fifo_empty = (count_q == '0);
    assign push       = I_col_valid && ready_q;
    assign step       = (state_q == StScroll) && I_enable && (div_cnt_q == DivLast);
    // With the FIFO empty the step still runs, shifting in a blank column.
    assign pop        = step && !fifo_empty;
    assign new_col    = pop ? mem[rd_ptr_q] : 5'b00000;

    always_comb begin
        frame_zero = 1'b1;
        for (int n = 0; n < 5; n++) begin
            rows_d[n] = {new_col[n], rows_q[n][4:1]};
            if (rows_d[n] != 5'b00000) frame_zero = 1'b0;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset; clear drops a same-cycle push.
    always_ff @(posedge PIXEL_CLK) begin
        if (push && !RST && !I_clear) mem[wr_ptr_q] <= I_col_data;
    end

    always_ff @(posedge PIXEL_CLK) begin
        if (RST || I_clear) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            shift_q   <= 1'b0;
            count_q   <= '0;
            ready_q   <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int n = 0; n < 5; n++) rows_q[n] <= 5'b00000;
        end else begin
            shift_q <= step;
            count_q <= count_d;
            ready_q <= (count_d != CountFull);
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case (state_q)
                StIdle: begin
                    div_cnt_q <= '0;
                    if (!fifo_empty && I_enable) state_q <= StScroll;
                end
                StScroll: begin
                    if (I_enable) begin
                        if (div_cnt_q == DivLast) begin
                            div_cnt_q <= '0;
                            for (int n = 0; n < 5; n++) rows_q[n] <= rows_d[n];
                            // Idle only once the last loaded column has left.
                            if (fifo_empty && frame_zero) state_q <= StIdle;
                        end else begin
                            div_cnt_q <= div_cnt_q + 32'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign row0        = rows_q[0];
    assign row1        = rows_q[1];
    assign row2        = rows_q[2];
    assign row3        = rows_q[3];
    assign row4        = rows_q[4];
    assign O_shift     = shift_q;
    assign O_empty     = fifo_empty;
    assign O_count     = count_q;
    assign O_col_ready = ready_q;

endmodule

// File: doc/matrix_scroll_feeder.md
# matrix_scroll_feeder

Column-stream frame generator for the 5x5 LED matrix. Buffers incoming 5-bit pixel columns in a small FIFO and scrolls them through a 5x5 frame at a programmable rate. Drives `row0`..`row4` of the row multiplexer directly. Owns scroll timing, drain-to-blank behaviour and producer backpressure.

## Interface

**Parameters**
- `SCROLL_DIV`, default 10_000_000: `PIXEL_CLK` cycles per scroll step. Range 2..2^32-1; 100 MHz gives 0.1 s per step.
- `FIFO_DEPTH`, default 8: column FIFO depth. Power of two, 2..64.

**Ports** (clock and reset first)
- `PIXEL_CLK` in 1: the single clock. All logic is on its rising edge.
- `RST` in 1: reset, synchronous and active-high. Priority over every other input.
- `I_enable` in 1: scroll counter advances only while high.
- `I_clear` in 1: one-cycle request; blanks the frame and empties the FIFO.
- `I_col_data` in 5: column to append. Bit r is the pixel in row r.
- `I_col_valid` in 1: `I_col_data` is valid.
- `O_col_ready` out 1: FIFO not full; registered.
- `row0`..`row4` out 5 each: frame rows. Bit c is column c; column 4 is the entry (right) edge.
- `O_shift` out 1: one-cycle pulse, asserted in the cycle after a scroll step updated the rows.
- `O_empty` out 1: FIFO empty.
- `O_count` out clog2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation

- **Push:** a column is accepted on an edge where `I_col_valid && O_col_ready`. `O_col_ready` is derived from registered occupancy.
  - No push when full, even if a pop happens in the same cycle.
- **FSM states:** IDLE and SCROLL.
  - **IDLE:** frame is all zero; scroll counter is held at 0.
    - Go to SCROLL when `!O_empty && I_enable`.
  - **SCROLL:** counter increments each cycle while `I_enable` is high and holds its value while low.
    - On `count == SCROLL_DIV-1`: counter returns to 0 and one scroll step executes.
- **Scroll step:** every row N takes `{new[N], rowN[4:1]}`.
  - `new` is the FIFO head, popped in the same edge, if the FIFO is non-empty; otherwise 5'b00000.
  - Columns enter at bit 4 and leave after bit 0.
- **Return to IDLE:** SCROLL goes to IDLE on a step where the FIFO was empty and the resulting frame is all zero.
  - A loaded column therefore fully scrolls off before the block idles.
- **Push and pop in the same edge:** occupancy is unchanged.
- **Push into an empty FIFO on a step edge:** that step shifts in blank; the pushed column is popped at a later step.
- **`I_clear`:** clears rows, FIFO pointers, occupancy and counter, and forces IDLE. It overrides any push or step in the same cycle; a push in that cycle is dropped.
- **Pointers:** FIFO pointers wrap modulo `FIFO_DEPTH`. Occupancy saturates neither way, because push-when-full and pop-when-empty are impossible by construction.
- **Counter:** 32-bit, compared against `SCROLL_DIV-1`, no overflow possible.

## Timing

- **Reset values:**
  - rows all 0, `O_shift`=0, `O_empty`=1, `O_count`=0, `O_col_ready`=1.
  - FSM in IDLE, counter at 0.
- **Push latency:** `O_count` and `O_empty` update one cycle after the accepting edge. `O_col_ready` falls in the cycle after the push that fills the FIFO.
- **IDLE→SCROLL:** transition occurs on the edge after the start condition is first true. The first step follows SCROLL_DIV enabled cycles after entering SCROLL.
- **Step latency:** rows update on the step edge. `O_shift` is high for exactly the following cycle. Each step period is SCROLL_DIV enabled cycles.
- **Reset or `I_clear` mid-scroll:** all state takes reset values at that edge; `O_shift` stays 0.
- **`I_enable` low in IDLE:** the block stays in IDLE regardless of FIFO contents.

## Test plan

All scenarios use SCROLL_DIV=4, FIFO_DEPTH=4.

- **Reset:** hold `RST` 2 cycles with valid high -> all rows 0, `O_col_ready`=1, `O_empty`=1, `O_count`=0, nothing accepted.
- **Single column:** push 5'b11111 with `I_enable`=1 -> SCROLL one cycle after `O_empty` falls.
  - After 4 cycles: all rows 5'b10000 and `O_shift` pulses.
  - Subsequent steps give 01000, 00100, 00010, 00001, then 00000 with return to IDLE. Total 6 `O_shift` pulses.
- **Fill:** push 5 columns with `I_enable`=0 -> first 4 accepted, `O_count`=4, `O_col_ready`=0, 5th held with valid high.
  - Raise `I_enable`: after the first step, `O_count` goes to 3 and `O_col_ready`=1.
  - The 5th column is accepted the next cycle, bringing `O_count` back to 4.
- **Pattern order:** push 00001, 00010, 00100 -> after 3 steps row0=5'b00100, row1=5'b01000, row2=5'b10000, other rows 0.
- **Pause:** drop `I_enable` for 10 cycles with counter at 2 -> no step while low; step occurs 2 enabled cycles after re-enable.
- **Clear:** assert `I_clear` mid-scroll together with a valid push -> next cycle rows 0, `O_count`=0, FSM IDLE, pushed column discarded, no `O_shift`.
